// File: rtl/neuron_teacher_pkg.sv
// rtl/neuron_teacher_pkg.sv - shared types for the neuron training sequencer
package neuron_teacher_pkg;

    // Unsigned fixed point, 8'd128 represents 1.0.
    typedef logic [7:0] zero2one_t;
    typedef logic [6:0] frac_t;

    localparam zero2one_t Z2O_ONE = 8'd128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EPOCH_END,
        ST_DONE
    } teacher_state_t;

    function automatic zero2one_t abs_diff(input zero2one_t a, input zero2one_t b);
        return (a >= b) ? zero2one_t'(a - b) : zero2one_t'(b - a);
    endfunction

endpackage

// File: rtl/neuron_teacher_if.sv
// rtl/neuron_teacher_if.sv - load/control and neuron-side bundle of the teacher
interface neuron_teacher_if #(
    parameter int N     = 16,
    parameter int ERR_W = 24
);
    import neuron_teacher_pkg::*;

    logic                  clear;
    logic                  load_valid;
    logic                  load_ready;
    zero2one_t [N-1:0]     load_in;
    zero2one_t             load_expected;
    logic                  start;
    logic                  learn_en;
    logic [ERR_W-1:0]      err_threshold;
    logic                  busy;
    logic                  done;
    logic                  converged;
    logic [7:0]            epoch_count;
    logic [ERR_W-1:0]      last_err;
    logic                  nrn_valid;
    logic                  nrn_learn;
    zero2one_t [N-1:0]     nrn_in;
    zero2one_t             nrn_out;
    zero2one_t             nrn_expected_out;

    modport slave (
        input  clear, load_valid, load_in, load_expected, start, learn_en,
               err_threshold, nrn_out,
        output load_ready, busy, done, converged, epoch_count, last_err,
               nrn_valid, nrn_learn, nrn_in, nrn_expected_out
    );

    modport master (
        output clear, load_valid, load_in, load_expected, start, learn_en,
               err_threshold, nrn_out,
        input  load_ready, busy, done, converged, epoch_count, last_err,
               nrn_valid, nrn_learn, nrn_in, nrn_expected_out
    );

endinterface

// File: rtl/neuron_teacher_sample_store.sv
// rtl/neuron_teacher_sample_store.sv - DEPTH-entry sample memory, append-only with clear
module neuron_teacher_sample_store
    import neuron_teacher_pkg::*;
#(
    parameter int N     = 16,
    parameter int DEPTH = 8,
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              wr_i,
    input  zero2one_t [N-1:0] wr_in_i,
    input  zero2one_t         wr_exp_i,
    input  logic [IW-1:0]     rd_idx_i,
    output zero2one_t [N-1:0] rd_in_o,
    output zero2one_t         rd_exp_o,
    output logic [CW-1:0]     count_o
);

    // Entry N of each row holds the expected output.
    zero2one_t [N:0]  mem_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic             do_wr;

    assign do_wr = wr_i && !clr_i && (count_q < CW'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (do_wr) begin
            count_q <= count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[count_q[IW-1:0]] <= {wr_exp_i, wr_in_i};
        end
    end

    assign rd_in_o  = mem_q[rd_idx_i][N-1:0];
    assign rd_exp_o = mem_q[rd_idx_i][N];
    assign count_o  = count_q;

endmodule

// File: rtl/neuron_teacher.sv
// rtl/neuron_teacher.sv - epoch replay sequencer that trains one neuron and sums its error
// NEURON_TEACHER_ROTATE_EN: each epoch starts one sample later than the previous one.
module neuron_teacher
    import neuron_teacher_pkg::*;
#(
    parameter int N          = 16,
    parameter int DEPTH      = 8,
    parameter int SETTLE     = 2,
    parameter int MAX_EPOCHS = 255,
    parameter int ERR_W      = 24
) (
    input logic       clk,
    input logic       rst_n,
    neuron_teacher_if.slave bus
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = ERR_W + 9;
    localparam logic [3:0]       SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    teacher_state_t    state_q;
    logic [IW-1:0]     idx_q;
    logic [CW-1:0]     seen_q;
    logic [3:0]        settle_q;
    logic [ERR_W-1:0]  acc_q;
    logic [ERR_W-1:0]  last_err_q;
    logic [7:0]        epoch_q;
    logic              converged_q;
    logic              load_ready_q;
    logic              nrn_learn_q;

    logic [CW-1:0]     count;
    logic [CW-1:0]     cnt_d;
    logic [CW-1:0]     last_idx;
    zero2one_t [N-1:0] rd_in;
    zero2one_t         rd_exp;
    zero2one_t         err;
    logic [SW-1:0]     sum_w;
    logic [ERR_W-1:0]  acc_sat;
    logic [IW-1:0]     idx_wrap;
    logic [IW-1:0]     epoch_start;
    logic              in_idle, in_done, busy_w, presenting;
    logic              clr_ok, wr_ok, start_ok, last_sample;

    assign in_idle    = (state_q == ST_IDLE);
    assign in_done    = (state_q == ST_DONE);
    assign busy_w     = !in_idle && !in_done;
    assign presenting = (state_q == ST_PRESENT) || (state_q == ST_SETTLE) ||
                        (state_q == ST_SAMPLE);

    assign clr_ok   = bus.clear && (in_idle || in_done);
    assign wr_ok    = in_idle && bus.load_valid && load_ready_q && !bus.clear;
    assign start_ok = bus.start && !clr_ok && ((in_idle && count != '0) || in_done);
    assign cnt_d    = clr_ok ? '0 : (wr_ok ? count + 1'b1 : count);

    neuron_teacher_sample_store #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_store (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (clr_ok),
        .wr_i     (wr_ok),
        .wr_in_i  (bus.load_in),
        .wr_exp_i (bus.load_expected),
        .rd_idx_i (idx_q),
        .rd_in_o  (rd_in),
        .rd_exp_o (rd_exp),
        .count_o  (count)
    );

    // Widened sum so a single error larger than the accumulator still saturates.
    assign err      = abs_diff(bus.nrn_out, rd_exp);
    assign sum_w    = SW'(acc_q) + SW'(err);
    assign acc_sat  = (sum_w > SW'(ERR_MAX)) ? ERR_MAX : sum_w[ERR_W-1:0];

    assign last_idx    = count - 1'b1;
    assign last_sample = (seen_q == last_idx);
    assign idx_wrap    = (CW'(idx_q) == last_idx) ? '0 : idx_q + 1'b1;

    // idx_q has wrapped back to this epoch's first sample by EPOCH_END.
`ifdef NEURON_TEACHER_ROTATE_EN
    assign epoch_start = idx_wrap;
`else
    assign epoch_start = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            seen_q       <= '0;
            settle_q     <= '0;
            acc_q        <= '0;
            last_err_q   <= '0;
            epoch_q      <= '0;
            converged_q  <= 1'b0;
            load_ready_q <= 1'b0;
            nrn_learn_q  <= 1'b0;
        end else begin
            nrn_learn_q <= bus.learn_en && busy_w;
            if (start_ok) begin
                state_q      <= ST_PRESENT;
                idx_q        <= '0;
                seen_q       <= '0;
                acc_q        <= '0;
                epoch_q      <= '0;
                converged_q  <= 1'b0;
                load_ready_q <= 1'b0;
                nrn_learn_q  <= bus.learn_en;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        load_ready_q <= (cnt_d < CW'(DEPTH));
                    end
                    ST_PRESENT: begin
                        settle_q <= '0;
                        state_q  <= (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        settle_q <= settle_q + 1'b1;
                        if (settle_q == SETTLE_LAST) begin
                            state_q <= ST_SAMPLE;
                        end
                    end
                    ST_SAMPLE: begin
                        acc_q <= acc_sat;
                        idx_q <= idx_wrap;
                        if (last_sample) begin
                            seen_q  <= '0;
                            state_q <= ST_EPOCH_END;
                        end else begin
                            seen_q  <= seen_q + 1'b1;
                            state_q <= ST_PRESENT;
                        end
                    end
                    ST_EPOCH_END: begin
                        last_err_q <= acc_q;
                        epoch_q    <= epoch_q + 1'b1;
                        acc_q      <= '0;
                        idx_q      <= epoch_start;
                        if (acc_q <= bus.err_threshold) begin
                            state_q     <= ST_DONE;
                            converged_q <= 1'b1;
                            nrn_learn_q <= 1'b0;
                        end else if (epoch_q == 8'(MAX_EPOCHS - 1)) begin
                            state_q     <= ST_DONE;
                            converged_q <= 1'b0;
                            nrn_learn_q <= 1'b0;
                        end else begin
                            state_q <= ST_PRESENT;
                        end
                    end
                    ST_DONE: begin
                        if (clr_ok) begin
                            state_q      <= ST_IDLE;
                            converged_q  <= 1'b0;
                            load_ready_q <= 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.load_ready       = load_ready_q;
    assign bus.busy             = busy_w;
    assign bus.done             = in_done;
    assign bus.converged        = converged_q;
    assign bus.epoch_count      = epoch_q;
    assign bus.last_err         = last_err_q;
    assign bus.nrn_valid        = (state_q == ST_PRESENT);
    assign bus.nrn_learn        = nrn_learn_q;
    assign bus.nrn_in           = presenting ? rd_in : '0;
    assign bus.nrn_expected_out = presenting ? rd_exp : '0;

endmodule

// File: tb/tb_neuron_teacher.sv
// tb/tb_neuron_teacher.sv - table-driven bench with a pulse scoreboard for neuron_teacher
module tb_neuron_teacher;
    import neuron_teacher_pkg::*;

    localparam int N      = 16;
    localparam int DEPTH  = 8;
    localparam int SETTLE = 2;
    localparam int MAX_EP = 4;
`ifdef NEURON_TEACHER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stub_echo = 1'b0;
    always #5 clk = ~clk;

    neuron_teacher_if #(.N(N), .ERR_W(24)) ifa ();
    neuron_teacher_if #(.N(N), .ERR_W(4))  ifb ();

    assign ifa.nrn_out       = stub_echo ? ifa.nrn_expected_out : 8'd64;
    assign ifb.nrn_out       = stub_echo ? ifb.nrn_expected_out : 8'd64;
    assign ifb.clear         = ifa.clear;
    assign ifb.load_valid    = ifa.load_valid;
    assign ifb.load_in       = ifa.load_in;
    assign ifb.load_expected = ifa.load_expected;
    assign ifb.start         = ifa.start;
    assign ifb.learn_en      = ifa.learn_en;
    assign ifb.err_threshold = ifa.err_threshold[3:0];

    neuron_teacher #(.N(N), .DEPTH(DEPTH), .SETTLE(SETTLE), .MAX_EPOCHS(MAX_EP), .ERR_W(24))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    neuron_teacher #(.N(N), .DEPTH(DEPTH), .SETTLE(SETTLE), .MAX_EPOCHS(MAX_EP), .ERR_W(4))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    typedef struct {
        zero2one_t        exp;
        logic [N*8-1:0]   vin;
        int               gap;
    } sb_t;

    typedef struct {
        logic [2:0][7:0]  exp;
        logic             echo;
        logic             learn;
        logic [23:0]      thr;
        logic [23:0]      last;
        logic             conv;
        int               ep;
        logic [3:0]       blast;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_pulse = 0;
    int   pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*8-1:0] make_in(input int k);
        logic [N*8-1:0] r;
        for (int j = 0; j < N; j++) r[j*8 +: 8] = 8'(k * 17 + j * 3 + 1);
        return r;
    endfunction

    task automatic push_epochs(input logic [2:0][7:0] exp, input int cnt, input int epochs);
        int idx;
        for (int e = 0; e < epochs; e++) begin
            for (int m = 0; m < cnt; m++) begin
                sb_t s;
                idx   = ROT ? (e + m) % cnt : m;
                s.exp = exp[idx];
                s.vin = make_in(idx);
                s.gap = (e == 0 && m == 0) ? 0 : ((m == 0) ? SETTLE + 3 : SETTLE + 2);
                sb.push_back(s);
            end
        end
    endtask

    task automatic monitor();
        sb_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ifa.nrn_valid) begin
                pulses++;
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 128'(1), 128'(0));
                end else begin
                    e = sb.pop_front();
                    check("pulse_expected_out", 128'(ifa.nrn_expected_out), 128'(e.exp));
                    check("pulse_in", 128'(ifa.nrn_in), 128'(e.vin));
                    check("pulse_learn", 128'(ifa.nrn_learn), 128'(ifa.learn_en));
                    if (e.gap != 0) check("pulse_gap", 128'(cyc - last_pulse), 128'(e.gap));
                end
                last_pulse = cyc;
            end
        end
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!(ifa.done && ifb.done) && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 128'(ifa.done && ifb.done), 128'(1));
    endtask

    task automatic load3(input logic [2:0][7:0] exp);
        ifa.clear = 1'b1;
        tick();
        ifa.clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ifa.load_valid    = 1'b1;
            ifa.load_in       = make_in(k);
            ifa.load_expected = exp[k];
            tick();
        end
        ifa.load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
    endtask

    initial begin
        int seen;
        int base;
        ifa.clear = 0; ifa.load_valid = 0; ifa.load_in = '0; ifa.load_expected = '0;
        ifa.start = 0; ifa.learn_en = 0; ifa.err_threshold = '0;
        fork monitor(); join_none

        // exp packed as {exp[2], exp[1], exp[0]}
        vecs[0] = '{{8'd128, 8'd32,  8'd64 }, 1'b0, 1'b0, 24'd0,  24'd96,  1'b0, MAX_EP, 4'd15};
        vecs[1] = '{{8'd128, 8'd32,  8'd64 }, 1'b1, 1'b1, 24'd0,  24'd0,   1'b1, 1,      4'd0 };
        vecs[2] = '{{8'd128, 8'd128, 8'd128}, 1'b0, 1'b0, 24'd0,  24'd192, 1'b0, MAX_EP, 4'd15};
        vecs[3] = '{{8'd128, 8'd32,  8'd64 }, 1'b0, 1'b0, 24'd96, 24'd96,  1'b1, 1,      4'd15};
        vecs[4] = '{{8'd128, 8'd32,  8'd64 }, 1'b0, 1'b0, 24'd95, 24'd96,  1'b0, MAX_EP, 4'd15};
        vecs[5] = '{{8'd64,  8'd255, 8'd0  }, 1'b0, 1'b0, 24'd0,  24'd255, 1'b0, MAX_EP, 4'd15};

        #2;
        check("reset_busy", 128'(ifa.busy), 128'(0));
        check("reset_done", 128'(ifa.done), 128'(0));
        check("reset_load_ready", 128'(ifa.load_ready), 128'(0));
        check("reset_nrn_valid", 128'(ifa.nrn_valid), 128'(0));
        check("reset_last_err", 128'(ifa.last_err), 128'(0));
        #10 rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            load3(vecs[v].exp);
            ifa.err_threshold = vecs[v].thr;
            ifa.learn_en      = vecs[v].learn;
            stub_echo         = vecs[v].echo;
            push_epochs(vecs[v].exp, 3, vecs[v].ep);
            pulse_start();
            wait_done(600);
            check($sformatf("v%0d_last_err", v), 128'(ifa.last_err), 128'(vecs[v].last));
            check($sformatf("v%0d_converged", v), 128'(ifa.converged), 128'(vecs[v].conv));
            check($sformatf("v%0d_epoch_count", v), 128'(ifa.epoch_count), 128'(vecs[v].ep));
            check($sformatf("v%0d_busy", v), 128'(ifa.busy), 128'(0));
            check($sformatf("v%0d_learn_idle", v), 128'(ifa.nrn_learn), 128'(0));
            check($sformatf("v%0d_sat_last_err", v), 128'(ifb.last_err), 128'(vecs[v].blast));
            check($sformatf("v%0d_sb_empty", v), 128'(sb.size()), 128'(0));
        end

        // Restart straight from DONE with the samples still loaded.
        push_epochs(vecs[5].exp, 3, MAX_EP);
        pulse_start();
        wait_done(600);
        check("restart_last_err", 128'(ifa.last_err), 128'(255));
        check("restart_epochs", 128'(ifa.epoch_count), 128'(MAX_EP));
        check("restart_sb_empty", 128'(sb.size()), 128'(0));

        // Fill the store and offer a ninth sample.
        ifa.clear = 1'b1;
        tick();
        ifa.clear = 1'b0;
        for (int k = 0; k < 9; k++) begin
            ifa.load_valid    = 1'b1;
            ifa.load_in       = make_in(k);
            ifa.load_expected = 8'(k * 20);
            tick();
        end
        ifa.load_valid = 1'b0;
        check("full_load_ready", 128'(ifa.load_ready), 128'(0));
        stub_echo = 1'b1;
        ifa.err_threshold = '0;
        ifa.learn_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sb_t s;
            s.exp = 8'(k * 20);
            s.vin = make_in(k);
            s.gap = (k == 0) ? 0 : SETTLE + 2;
            sb.push_back(s);
        end
        pulse_start();
        wait_done(600);
        check("full_converged", 128'(ifa.converged), 128'(1));
        check("full_epochs", 128'(ifa.epoch_count), 128'(1));
        check("full_sb_empty", 128'(sb.size()), 128'(0));

        // Start with an empty store must be ignored.
        ifa.clear = 1'b1;
        tick();
        ifa.clear = 1'b0;
        base = pulses;
        pulse_start();
        tick();
        tick();
        check("empty_start_busy", 128'(ifa.busy), 128'(0));
        check("empty_start_done", 128'(ifa.done), 128'(0));
        check("empty_start_pulses", 128'(pulses), 128'(base));

        // Asynchronous reset during SETTLE of the second sample.
        stub_echo = 1'b0;
        load3(vecs[0].exp);
        push_epochs(vecs[0].exp, 3, MAX_EP);
        base = pulses;
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        seen = 0;
        for (int n = 0; n < 100 && seen < 2; n++) begin
            @(negedge clk);
            if (ifa.nrn_valid) seen++;
        end
        check("rst_wait_pulse2", 128'(seen), 128'(2));
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 128'(ifa.busy), 128'(0));
        check("rst_mid_nrn_in", 128'(ifa.nrn_in), 128'(0));
        check("rst_mid_expected", 128'(ifa.nrn_expected_out), 128'(0));
        check("rst_mid_learn", 128'(ifa.nrn_learn), 128'(0));
        check("rst_mid_epoch", 128'(ifa.epoch_count), 128'(0));
        check("rst_mid_last_err", 128'(ifa.last_err), 128'(0));
        check("rst_mid_load_ready", 128'(ifa.load_ready), 128'(0));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        tick();
        tick();
        check("post_rst_busy", 128'(ifa.busy), 128'(0));
        check("post_rst_pulses", 128'(pulses), 128'(base + 2));
        check("post_rst_load_ready", 128'(ifa.load_ready), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
